// File: rtl/cordic_gain_comp.sv
// cordic_gain_comp
//   Output stage for the 8-iteration CORDIC core. It multiplies res1/res2 by
//   K (~0.60725) to remove the CORDIC gain. The core has no valid signal, so a
//   {valid, mode} tag travels down a delay line that matches the core latency.
//   Results are then queued in a small FIFO with a valid/ready handshake,
//   because the core itself cannot be stalled.
//   All data words are 16-bit sign-magnitude: bit15 = sign, bits14:0 = Q7.8
//   magnitude.
//
// Ports
//   clk        rising-edge clock, shared with the core
//   reset      asynchronous active-low reset, shared with the core
//   in_valid   a sample is presented to the core in this cycle
//   mode       mode of that sample: 1 = rotation, 0 = vectoring
//   res1/res2  core results (res2 is the z angle in vectoring mode)
//   out_valid  the FIFO head holds a result
//   out_ready  the consumer takes the head at this edge
//   out_x      compensated res1
//   out_y      compensated res2 (rotation) or raw res2 (vectoring)
//   out_count  FIFO occupancy, 0..DEPTH
//   ovf        sticky: a result was dropped because the FIFO was full
module cordic_gain_comp #(
   parameter int          LATENCY = 8,
   parameter logic [15:0] K_GAIN  = 16'h9B75,
   parameter int          DEPTH   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic                     mode,
   input  logic [15:0]              res1,
   input  logic [15:0]              res2,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [15:0]              out_x,
   output logic [15:0]              out_y,
   output logic [$clog2(DEPTH):0]   out_count,
   output logic                     ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Tag delay line. The tail lines up with the core result for the sample.
   logic [LATENCY-1:0] tag_v_sr, tag_m_sr;
   logic               tag_v, tag_m;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_v_sr <= '0;
         tag_m_sr <= '0;
      end else begin
         tag_v_sr[0] <= in_valid;
         tag_m_sr[0] <= mode;
         for (int i = 1; i < LATENCY; i++) begin
            tag_v_sr[i] <= tag_v_sr[i-1];
            tag_m_sr[i] <= tag_m_sr[i-1];
         end
      end
   end

   assign tag_v = tag_v_sr[LATENCY-1];
   assign tag_m = tag_m_sr[LATENCY-1];

   // Stage A: multiply each magnitude by K. The products are 31-bit unsigned.
   logic [30:0] p1_c, p2_c;
   assign p1_c = {16'd0, res1[14:0]} * {15'd0, K_GAIN};
   assign p2_c = {16'd0, res2[14:0]} * {15'd0, K_GAIN};

   logic        a_v, a_s1, a_m;
   logic [30:0] a_p1, a_p2;
   logic [15:0] a_r2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_v  <= 1'b0;
         a_s1 <= 1'b0;
         a_m  <= 1'b0;
         a_p1 <= '0;
         a_p2 <= '0;
         a_r2 <= '0;
      end else begin
         a_v <= tag_v;
         if (tag_v) begin
            a_s1 <= res1[15];
            a_m  <= tag_m;
            a_p1 <= p1_c;
            a_p2 <= p2_c;
            a_r2 <= res2;
         end
      end
   end

   // Stage B: round half up to Q7.8. Because K < 1, the result always fits in
   // 15 bits, so no saturation is needed. A zero magnitude is given a plus
   // sign (-0 becomes +0). The vectoring angle is passed through bit-exact.
   logic [14:0] mag1, mag2;
   assign mag1 = 15'((a_p1 + 31'd32768) >> 16);
   assign mag2 = 15'((a_p2 + 31'd32768) >> 16);

   logic        b_v;
   logic [15:0] b_x, b_y;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         b_v <= 1'b0;
         b_x <= '0;
         b_y <= '0;
      end else begin
         b_v <= a_v;
         if (a_v) begin
            b_x <= {a_s1 & (mag1 != '0), mag1};
            b_y <= a_m ? {a_r2[15] & (mag2 != '0), mag2} : a_r2;
         end
      end
   end

   // Output FIFO. A count register tells full apart from empty.
   // When the FIFO is empty, the outputs show the last word that was popped.
   logic [15:0]   mem_x [DEPTH];
   logic [15:0]   mem_y [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic [15:0]   hold_x, hold_y;
   logic          full, pop, wr;

   assign full = (count == CW'(DEPTH));
   assign pop  = out_valid & out_ready;
   // When the FIFO is full, a write can go in only if the head leaves at the
   // same edge. It then reuses the slot being freed.
   assign wr   = b_v & (~full | pop);

   always_ff @(posedge clk) begin
      if (wr) begin
         mem_x[wptr] <= b_x;
         mem_y[wptr] <= b_y;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr   <= '0;
         rptr   <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         hold_x <= '0;
         hold_y <= '0;
      end else begin
         if (wr) wptr <= wptr + AW'(1);
         if (pop) begin
            rptr   <= rptr + AW'(1);
            hold_x <= mem_x[rptr];
            hold_y <= mem_y[rptr];
         end
         if (wr && !pop)      count <= count + CW'(1);
         else if (!wr && pop) count <= count - CW'(1);
         if (b_v && full && !pop) ovf <= 1'b1;
      end
   end

   assign out_valid = (count != '0);
   assign out_x     = out_valid ? mem_x[rptr] : hold_x;
   assign out_y     = out_valid ? mem_y[rptr] : hold_y;
   assign out_count = count;

endmodule
